// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
// Shared frame-format definitions for the UART receiver (and its uart_tx peer).
//   - state_t         : FSM state encodings (IDLE=0 .. BREAK=5); PARITY is only
//                       reachable when the design is built with UART_RX_PARITY_EN.
//   - UART_OVERSAMPLE : default clk_baud cycles per serial bit.
//   - UART_DATA_BITS  : default data bits per frame.
// Keeping these in one place lets transmitter and receiver agree on framing.
// -----------------------------------------------------------------------------
package uart_rx_pkg;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

endpackage : uart_rx_pkg

// File: rtl/uart_sync2.sv
// -----------------------------------------------------------------------------
// uart_sync2
// Two-flop synchroniser for asynchronous inputs. Both stages preset to 1 so an
// idle-high serial line does not look like a start bit coming out of reset.
// Ports:
//   clk   : destination clock
//   rst_n : asynchronous active-low reset (flops preset to 1)
//   d     : asynchronous input(s)
//   q     : synchronised output(s), two-cycle latency
// -----------------------------------------------------------------------------
module uart_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic meta_reg;
            logic sync_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    meta_reg <= 1'b1;
                    sync_reg <= 1'b1;
                end else begin
                    meta_reg <= d[gi];
                    sync_reg <= meta_reg;
                end
            end

            assign q[gi] = sync_reg;
        end
    endgenerate

endmodule : uart_sync2

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// Oversampling UART receiver for 8N1-style frames: start(0), DATA_BITS data
// bits LSB first, optional even-parity bit, stop(1).
// Optional feature macro: UART_RX_PARITY_EN
//   defined   -> PARITY state between DATA and STOP, extra output parity_err.
//   undefined -> frame is 1 + DATA_BITS + 1 bits, no parity_err port.
// Ports:
//   clk_baud   : OVERSAMPLE x bit-rate clock, rising edge
//   rst        : asynchronous active-low reset
//   rx_in      : asynchronous serial line, idle high
//   bus_out    : last correctly framed byte, held until the next good frame
//   rx_valid   : one-cycle pulse, bus_out updated this cycle
//   frame_err  : one-cycle pulse, stop bit sampled low
//   parity_err : (UART_RX_PARITY_EN only) pulses with rx_valid on bad parity
// -----------------------------------------------------------------------------
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_BITS  = UART_DATA_BITS
) (
    input  logic                 clk_baud,
    input  logic                 rst,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] bus_out,
    output logic                 rx_valid,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 frame_err
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    logic rx_s;

    state_t               state_reg,  state_next;
    logic [TICK_W-1:0]    tick_reg,   tick_next;
    logic [BIT_W-1:0]     bit_reg,    bit_next;
    logic [DATA_BITS-1:0] shreg_reg,  shreg_next;
    logic [DATA_BITS-1:0] bus_reg,    bus_next;
    logic                 valid_reg,  valid_next;
    logic                 ferr_reg,   ferr_next;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad_reg, par_bad_next;
    logic                 perr_reg,    perr_next;
`endif

    uart_sync2 #(
        .WIDTH (1)
    ) u_sync (
        .clk   (clk_baud),
        .rst_n (rst),
        .d     (rx_in),
        .q     (rx_s)
    );

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk_baud or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            tick_reg    <= '0;
            bit_reg     <= '0;
            shreg_reg   <= '0;
            bus_reg     <= '0;
            valid_reg   <= 1'b0;
            ferr_reg    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_reg <= 1'b0;
            perr_reg    <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            tick_reg    <= tick_next;
            bit_reg     <= bit_next;
            shreg_reg   <= shreg_next;
            bus_reg     <= bus_next;
            valid_reg   <= valid_next;
            ferr_reg    <= ferr_next;
`ifdef UART_RX_PARITY_EN
            par_bad_reg <= par_bad_next;
            perr_reg    <= perr_next;
`endif
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (!rx_s) state_next = START;
            // Mid start bit: a line that is high again was only a glitch.
            START: if (tick_reg == TICK_HALF) state_next = rx_s ? IDLE : DATA;
            DATA:  if (tick_reg == TICK_LAST && bit_reg == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                       state_next = PARITY;
`else
                       state_next = STOP;
`endif
                   end
`ifdef UART_RX_PARITY_EN
            PARITY: if (tick_reg == TICK_LAST) state_next = STOP;
`endif
            // Leaving at mid stop bit lets an immediately following start
            // edge be caught.
            STOP:  if (tick_reg == TICK_LAST) state_next = rx_s ? IDLE : BREAK;
            // A held-low line reports once, then waits for idle.
            BREAK: if (rx_s) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------------------------------------------------------- outputs / datapath
    always_comb begin
        bit_next     = bit_reg;
        shreg_next   = shreg_reg;
        bus_next     = bus_reg;
        valid_next   = 1'b0;
        ferr_next    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_next = par_bad_reg;
        perr_next    = 1'b0;
`endif
        // Tick restarts on every state change so each state measures from its
        // own entry; within DATA it wraps once per bit.
        if (state_next != state_reg || tick_reg == TICK_LAST) begin
            tick_next = '0;
        end else begin
            tick_next = tick_reg + TICK_W'(1);
        end

        case (state_reg)
            IDLE: begin
                tick_next    = '0;
                bit_next     = '0;
`ifdef UART_RX_PARITY_EN
                par_bad_next = 1'b0;
`endif
            end
            DATA: begin
                if (tick_reg == TICK_LAST) begin
                    // LSB arrives first, so shifting in at the MSB end leaves
                    // bit 0 in place after the last data bit.
                    shreg_next = {rx_s, shreg_reg[DATA_BITS-1:1]};
                    bit_next   = bit_reg + BIT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                // Even parity: data XOR parity bit must be zero.
                if (tick_reg == TICK_LAST) par_bad_next = rx_s ^ (^shreg_reg);
            end
`endif
            STOP: begin
                if (tick_reg == TICK_LAST) begin
                    if (rx_s) begin
                        bus_next   = shreg_reg;
                        valid_next = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_next  = par_bad_reg;
`endif
                    end else begin
                        ferr_next  = 1'b1;
                    end
                end
            end
            BREAK: tick_next = '0;
            default: ;
        endcase
    end

    assign bus_out   = bus_reg;
    assign rx_valid  = valid_reg;
    assign frame_err = ferr_reg;
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_reg;
`endif

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Scoreboard bench for uart_rx. A bench-side serialiser plays the uart_tx role
// and pushes the expected strobe (kind, byte, parity flag, cycle) when a frame
// starts; a monitor pops and compares whenever rx_valid or frame_err fires.
// Build with +define+UART_RX_PARITY_EN to exercise the parity variant.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int OS = 16;
    localparam int DB = 8;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 2 + OS / 2 + (DB + 1) * OS + OS;
`else
    localparam int LAT = 2 + OS / 2 + (DB + 1) * OS;
`endif

    typedef struct {
        int         kind;   // 1 = rx_valid, 2 = frame_err
        logic [7:0] data;   // bus_out expected at the strobe
        bit         perr;
        int         cyc;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          rx_in;
    logic [DB-1:0] bus_out;
    logic          rx_valid;
    logic          frame_err;
`ifdef UART_RX_PARITY_EN
    logic          parity_err;
`endif

    exp_t       sb_q[$];
    exp_t       mon_e;
    int         cyc;
    int         n_vectors;
    int         n_miscompares;
    logic [7:0] last_good;

    uart_rx #(
        .OVERSAMPLE (OS),
        .DATA_BITS  (DB)
    ) dut (
        .clk_baud   (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .bus_out    (bus_out),
        .rx_valid   (rx_valid),
`ifdef UART_RX_PARITY_EN
        .parity_err (parity_err),
`endif
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vectors++;
        if (obs !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Called right after a negedge; returns right after a negedge.
    task automatic drive_bit(input logic b);
        rx_in = b;
        repeat (OS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_val,
                              input logic par_val, input int kind);
        exp_t e;
        e.kind = kind;
        e.data = (kind == 1) ? d : last_good;
        e.perr = (par_val != ^d);
        e.cyc  = cyc + 1 + LAT;   // next posedge is the first to see the start bit
        if (kind != 0) sb_q.push_back(e);
        if (kind == 1) last_good = d;
        drive_bit(1'b0);
        for (int i = 0; i < DB; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par_val);
`endif
        drive_bit(stop_val);
    endtask

    // Monitor: one line per received strobe, compared against the scoreboard.
    always @(negedge clk) begin
        if (rst && (rx_valid || frame_err)) begin
            if (sb_q.size() == 0) begin
                check("unexpected_strobe", {30'd0, rx_valid, frame_err}, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                $display("strobe cyc=%0d rx_valid=%0b frame_err=%0b bus_out=%02h",
                         cyc, rx_valid, frame_err, bus_out);
                check("rx_valid",  {31'd0, rx_valid},  {31'd0, mon_e.kind == 1});
                check("frame_err", {31'd0, frame_err}, {31'd0, mon_e.kind == 2});
                check("bus_out",   {24'd0, bus_out},   {24'd0, mon_e.data});
                check("latency",   cyc,                mon_e.cyc);
`ifdef UART_RX_PARITY_EN
                check("parity_err", {31'd0, parity_err}, {31'd0, mon_e.perr});
`endif
            end
        end
    end

    initial begin
        n_vectors     = 0;
        n_miscompares = 0;
        last_good     = 8'h00;
        rst           = 1'b0;
        rx_in         = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_bus_out",   {24'd0, bus_out},   32'd0);
        check("reset_rx_valid",  {31'd0, rx_valid},  32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // 1: single frame, checks 154-edge latency
        send_frame(8'h55, 1'b1, ^8'h55, 1);
        repeat (2 * OS) @(negedge clk);

        // 2: back-to-back frames
        send_frame(8'hAA, 1'b1, ^8'hAA, 1);
        send_frame(8'h55, 1'b1, ^8'h55, 1);
        repeat (2 * OS) @(negedge clk);

        // 3: short low glitch, then a real frame
        rx_in = 1'b0;
        repeat (4) @(negedge clk);
        rx_in = 1'b1;
        repeat (2 * OS) @(negedge clk);
        send_frame(8'h3C, 1'b1, ^8'h3C, 1);
        repeat (2 * OS) @(negedge clk);

        // 4: bad stop bit, line held low 40 bit-times -> one frame_err
        send_frame(8'hF0, 1'b0, ^8'hF0, 2);
        repeat (40 * OS) @(negedge clk);
        rx_in = 1'b1;
        repeat (2 * OS) @(negedge clk);
        send_frame(8'h0F, 1'b1, ^8'h0F, 1);
        repeat (2 * OS) @(negedge clk);

        // 5: reset in the middle of data bit 4 of 0xC3
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(logic'((8'hC3 >> i) & 8'h01));
        rx_in = 1'b0;   // bit 4 of 0xC3
        repeat (OS / 2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_bus_out",   {24'd0, bus_out},   32'd0);
        check("rst_rx_valid",  {31'd0, rx_valid},  32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        rx_in = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        last_good = 8'h00;
        repeat (3 * OS) @(negedge clk);
        send_frame(8'h81, 1'b1, ^8'h81, 1);
        repeat (2 * OS) @(negedge clk);

`ifdef UART_RX_PARITY_EN
        // 6: good and bad parity on 0x07
        send_frame(8'h07, 1'b1, 1'b1, 1);
        repeat (2 * OS) @(negedge clk);
        send_frame(8'h07, 1'b1, 1'b0, 1);
        repeat (2 * OS) @(negedge clk);
`endif

        repeat (4 * OS) @(negedge clk);
        check("pending_strobes", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule : tb_uart_rx

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver; the downstream peer of uart_tx.
- Consumes the serial line that uart_tx drives on tx_out and recovers 8N1 frames: 1 start bit (0), DATA_BITS data bits LSB first, 1 stop bit (1).
- Each recovered byte is presented on a parallel bus with a one-cycle valid strobe. Bad frames raise a framing-error strobe.
- Runs on the same clk_baud domain as uart_tx, oversampled: clk_baud = OVERSAMPLE × bit rate.

Parameters:
- OVERSAMPLE, 16: clk_baud cycles per serial bit; even, >= 4.
- DATA_BITS, 8: data bits per frame; 5..8.

Ports:
- clk_baud, in, 1: single clock, OVERSAMPLE × bit rate; all logic on rising edge.
- rst, in, 1: asynchronous, active-low reset.
- rx_in, in, 1: serial line, asynchronous to clk_baud; idle high.
- bus_out, out, DATA_BITS: last correctly received byte; held until the next good frame.
- rx_valid, out, 1: one-cycle pulse; bus_out was updated this cycle.
- frame_err, out, 1: one-cycle pulse; stop bit sampled low.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; bus_out=0, rx_valid=0, frame_err=0.
  - Synchroniser flops preset to 1.
  - Counters and shift register cleared.
  - Reset mid-frame discards the partial frame with no strobe. The first rising clk_baud after rst releases starts in IDLE.
- rx_in passes through a 2-flop synchroniser; rx_s is the synchronised value, 2-cycle latency. All decisions use rx_s.
- Counters:
  - tick counter, width clog2(OVERSAMPLE), wraps at OVERSAMPLE-1.
  - bit counter, width clog2(DATA_BITS+1).
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: on rx_s==0 go to START with tick=0.
  - START: at tick==OVERSAMPLE/2-1, sample rx_s (mid start bit).
    - rx_s==1: glitch; return to IDLE, no strobe.
    - rx_s==0: go to DATA with tick=0, bit=0.
  - DATA: at tick==OVERSAMPLE-1 (mid-bit), shift rx_s into shreg MSB end (LSB first on the wire), bit++.
    - After DATA_BITS samples, go to STOP with tick=0.
  - STOP: at tick==OVERSAMPLE-1, sample rx_s.
    - rx_s==1: bus_out<=shreg, rx_valid=1 for one cycle, go to IDLE.
    - rx_s==0: frame_err=1 for one cycle, bus_out unchanged, go to BREAK.
  - BREAK: wait for rx_s==1, then go to IDLE. A held-low line produces exactly one frame_err, not repeated frames.
- Latency: rx_valid is high in the cycle exactly 2 + OVERSAMPLE/2 + (DATA_BITS+1)·OVERSAMPLE clk_baud edges after the first edge that samples rx_in low. Default parameters give 154.
- Back-to-back frames: IDLE is re-entered at mid stop bit, so a start edge that follows the stop bit immediately is accepted.
- rx_valid and frame_err are mutually exclusive and never high in consecutive cycles for one frame.
- No backpressure. The consumer must take bus_out within one frame time.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - One even-parity bit is sampled at mid-bit.
  - Extra output port parity_err (1 bit, reset 0) pulses in the same cycle as rx_valid when the parity mismatches. bus_out is still updated.
  - Latency grows by OVERSAMPLE.
- Undefined: no PARITY state, no parity_err port, frame = 1+DATA_BITS+1 bits.

Decomposition:
- Shared header uart_defs.vh:
  - state encodings: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, BREAK=5.
  - UART_OVERSAMPLE and UART_DATA_BITS defaults, so uart_tx and uart_rx agree on the frame format.
- One sub-module, uart_sync2: the 2-flop synchroniser with async active-low reset preset to 1. Reused for any other asynchronous input.

Test Plan:
1. Drive an 8N1 frame 0x55 at 16 cycles/bit after reset -> rx_valid one cycle, 154 edges after the falling edge; bus_out=0x55; frame_err=0.
2. Loopback: uart_tx.tx_out -> rx_in; send 0xAA then 0x55 back-to-back -> two rx_valid pulses, bus_out 0xAA then 0x55, no frame_err.
3. Low glitch of 4 cycles on idle line -> returns to IDLE; no rx_valid, no frame_err; a following 0x3C frame is received correctly.
4. Frame 0xF0 with stop bit forced 0, line then held low 40 bit-times -> exactly one frame_err pulse; bus_out keeps its previous value. After the line returns high, frame 0x0F is received with rx_valid.
5. Assert rst low during data bit 4 of 0xC3, release for 2 cycles, then send 0x81 -> no strobe for the aborted frame; outputs 0 during reset; 0x81 received correctly.
6. With UART_RX_PARITY_EN defined: frame 0x07 with parity bit 1 -> rx_valid, parity_err=0. Same frame with parity bit 0 -> rx_valid and parity_err=1 in the same cycle, bus_out=0x07.
